muldiv_unit: RTL and testbench

//  Iterative 32-step multiply/divide unit in the execute stage, beside the ALU.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/muldiv_addsub.sv | 22 ++
 rtl/muldiv_unit.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mips_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_STEPS = MD_WIDTH;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } md_state_e;

endpackage

// File: rtl/muldiv_addsub.sv
// (Width+1)-bit adder/subtractor shared by the shift-add and restoring-divide steps.
// carry_o is the carry out on add and the borrow out on subtract.
module muldiv_addsub #(
  parameter int unsigned Width = 32
) (
  input  logic [Width:0] a_i,
  input  logic [Width:0] b_i,
  input  logic           sub_i,
  output logic [Width:0] res_o,
  output logic           carry_o
);

  // Extend by one bit so the top bit of the result is the carry/borrow.
  always_comb begin
    if (sub_i) begin
      {carry_o, res_o} = {1'b0, a_i} - {1'b0, b_i};
    end else begin
      {carry_o, res_o} = {1'b0, a_i} + {1'b0, b_i};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One multiplier/quotient bit per cycle on operand magnitudes, signs applied in FIX.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int unsigned Width = MD_STEPS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] LastStep = CntW'(Width - 1);

  md_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Mul: {partial product, remaining multiplier}. Div: {remainder, dividend/quotient}.
  logic [2*Width-1:0] prod_q, prod_d;
  // Multiplicand magnitude for mul, divisor magnitude for div.
  logic [Width-1:0]  opnd_q, opnd_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              div_zero_q, div_zero_d;
  logic [Width-1:0]  hi_q, hi_d;
  logic [Width-1:0]  lo_q, lo_d;
  logic              done_q, done_d;

  muldiv_op_e        op_e;
  logic              op_signed;
  logic              op_is_div;
  logic [Width-1:0]  a_mag;
  logic [Width-1:0]  b_mag;

  logic [Width:0]    as_a;
  logic [Width:0]    as_b;
  logic [Width:0]    as_res;
  logic              as_carry;
  logic [2*Width-1:0] step_prod;

  logic [2*Width-1:0] mul_res;
  logic [Width-1:0]  quo;
  logic [Width-1:0]  rem;
  logic [Width-1:0]  div_hi;
  logic [Width-1:0]  div_lo;

  assign op_e      = muldiv_op_e'(op_i);
  assign op_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign op_is_div = (op_e == MD_DIV) || (op_e == MD_DIVU);
  assign a_mag     = (op_signed && a_i[Width-1]) ? -a_i : a_i;
  assign b_mag     = (op_signed && b_i[Width-1]) ? -b_i : b_i;

  // Div subtracts the divisor from {remainder, next dividend bit}; mul adds the multiplicand.
  assign as_a = is_div_q ? prod_q[2*Width-1:Width-1] : {1'b0, prod_q[2*Width-1:Width]};
  assign as_b = {1'b0, opnd_q};

  muldiv_addsub #(
    .Width (Width)
  ) u_addsub (
    .a_i     (as_a),
    .b_i     (as_b),
    .sub_i   (is_div_q),
    .res_o   (as_res),
    .carry_o (as_carry)
  );

  // One iteration of shift-add or restoring division.
  always_comb begin
    step_prod = prod_q;
    if (is_div_q) begin
      if (as_carry) begin
        step_prod = {prod_q[2*Width-2:0], 1'b0};
      end else begin
        step_prod = {as_res[Width-1:0], prod_q[Width-2:0], 1'b1};
      end
    end else begin
      if (prod_q[0]) begin
        step_prod = {as_res, prod_q[Width-1:1]};
      end else begin
        step_prod = {1'b0, prod_q[2*Width-1:1]};
      end
    end
  end

  // Sign correction of the finished magnitudes; divide by zero forces an all-ones quotient.
  always_comb begin
    mul_res = neg_q ? -prod_q : prod_q;
    quo     = prod_q[Width-1:0];
    rem     = prod_q[2*Width-1:Width];
    div_hi  = rem_neg_q ? -rem : rem;
    div_lo  = div_zero_q ? {Width{1'b1}} : (neg_q ? -quo : quo);
  end

  // Next-state, operand latching and HI/LO write decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            case (op_e)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                state_d    = CALC;
                cnt_d      = '0;
                is_div_d   = op_is_div;
                neg_d      = op_signed && (a_i[Width-1] ^ b_i[Width-1]);
                rem_neg_d  = op_signed && a_i[Width-1];
                div_zero_d = op_is_div && (b_i == '0);
                if (op_is_div) begin
                  prod_d = {{Width{1'b0}}, a_mag};
                  opnd_d = b_mag;
                end else begin
                  prod_d = {{Width{1'b0}}, b_mag};
                  opnd_d = a_mag;
                end
              end
              MD_MTHI: hi_d = a_i;
              MD_MTLO: lo_d = a_i;
              default: ;
            endcase
          end
        end
        CALC: begin
          prod_d = step_prod;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LastStep) begin
            state_d = FIX;
          end
        end
        FIX: begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (is_div_q) begin
            hi_d = div_hi;
            lo_d = div_lo;
          end else begin
            hi_d = mul_res[2*Width-1:Width];
            lo_d = mul_res[Width-1:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, datapath and architectural HI/LO registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prod_q     <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a scoreboard of expected {HI, LO} results.
module tb_muldiv_unit;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [63:0] sb_q[$];

  muldiv_unit #(
    .Width (32)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .flush_i (flush),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running count of done pulses, sampled away from the active edge.
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference using native 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] ma,
                                        input logic [31:0] mb);
    longint sa = $signed(ma);
    longint sb = $signed(mb);
    longint unsigned ua = ma;
    longint unsigned ub = mb;
    case (mop)
      OpMult:  return 64'(sa * sb);
      OpMultu: return ua * ub;
      OpDiv:   return (mb == 0) ? {ma, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      OpDivu:  return (mb == 0) ? {ma, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
      default: return 64'h0;
    endcase
  endfunction

  // Issue one mul/div, wait for done with a bound, then compare against the scoreboard.
  task automatic run_op(input string tag, input logic [2:0] top, input logic [31:0] ta,
                        input logic [31:0] tb, input logic [63:0] exp);
    int n;
    int d0;
    logic [63:0] want;
    sb_q.push_back(exp);
    d0 = done_cnt;
    start = 1'b1; op = top; a = ta; b = tb;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
    want = sb_q.pop_front();
    check({tag, "_hilo"}, {hi, lo}, want);
    tick();
    check({tag, "_done_pulse"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int d0;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, done, hi, lo}, 66'd0);
    rst_n = 1'b1;
    tick();

    // Reset mid-operation clears HI and never pulses done.
    start = 1'b1; op = OpMthi; a = 32'h55;
    tick();
    start = 1'b0;
    check("mthi_pre", {32'd0, hi}, 64'h55);
    d0 = done_cnt;
    start = 1'b1; op = OpMultu; a = 32'd7; b = 32'd6;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("midrst_nodone", 64'(done_cnt - d0), 64'd0);

    run_op("mult_signed", OpMult, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("multu_ovf", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("div_signed", OpDiv, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu", OpDivu, 32'd100, 32'd7, {32'd2, 32'd14});
    run_op("divu_zero", OpDivu, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF});
    run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op("rand_op", 3'(i), ra, rb, model(3'(i), ra, rb));
    end

    // Second start while busy is ignored: one pulse, original result.
    d0 = done_cnt;
    sb_q.push_back(64'd12);
    start = 1'b1; op = OpMultu; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; op = OpDivu; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (60) tick();
    check("busy_start_pulses", 64'(done_cnt - d0), 64'd1);
    check("busy_start_hilo", {hi, lo}, sb_q.pop_front());

    // Flush at step 5 aborts with HI/LO untouched.
    d0 = done_cnt;
    start = 1'b1; op = OpMultu; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0;
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    repeat (40) tick();
    check("flush_hilo", {hi, lo}, 64'd12);
    check("flush_nodone", 64'(done_cnt - d0), 64'd0);

    // Flush together with start in IDLE drops the start.
    flush = 1'b1; start = 1'b1; op = OpMthi; a = 32'hDEAD_BEEF;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_start_hi", {32'd0, hi}, 64'd0);
    check("flush_start_busy", {63'd0, busy}, 64'd0);

    // MTHI / MTLO write in one edge with no busy or done.
    d0 = done_cnt;
    start = 1'b1; op = OpMthi; a = 32'hCAFE_F00D;
    tick();
    check("mthi_hi", {32'd0, hi}, 64'hCAFE_F00D);
    check("mthi_busy", {63'd0, busy}, 64'd0);
    op = OpMtlo; a = 32'h0BAD_CAFE;
    tick();
    start = 1'b0;
    check("mtlo_hilo", {hi, lo}, 64'hCAFE_F00D_0BAD_CAFE);

    // Unknown op code is ignored.
    start = 1'b1; op = 3'd7; a = 32'h1;
    tick();
    start = 1'b0;
    check("unknown_op", {31'd0, busy, hi, lo}, {32'd0, 64'hCAFE_F00D_0BAD_CAFE});
    tick();
    check("mt_nodone", 64'(done_cnt - d0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
